// File: rtl/core_pkg.sv
// Shared types, pack masks and range limits for the RV32 immediate encoder.
// The range helper is only referenced when IMM_RANGE_CHECK_EN is defined.
package core_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  localparam logic [31:0] IMM_MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] IMM_MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] IMM_MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] IMM_MASK_J = 32'hFFFF_F000;

  localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_IS_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX  = 32'sd4094;
  localparam logic signed [31:0] IMM_J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX  = 32'sd1048574;

  // B and J targets are halfword aligned, so bit 0 must be clear as well
  function automatic logic imm_out_of_range(input logic [31:0] imm, input imm_src_e src);
    logic signed [31:0] v;
    logic               bad;
    v = $signed(imm);
    case (src)
      IMM_I, IMM_S: bad = (v < IMM_IS_MIN) || (v > IMM_IS_MAX);
      IMM_B:        bad = (v < IMM_B_MIN) || (v > IMM_B_MAX) || imm[0];
      IMM_J:        bad = (v < IMM_J_MIN) || (v > IMM_J_MAX) || imm[0];
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational scatter of an immediate into RV32 I/S/B/J instruction bit
// positions; produces the packed bits and the mask of fields it owns.
module imm_pack
  import core_pkg::*;
(
  input  logic [31:0] imm_i,
  input  imm_src_e    src_i,
  output logic [31:0] pack_o,
  output logic [31:0] mask_o
);

  // Bits above imm[20] never reach any format; they only matter to the range check
  logic imm_unused;
  assign imm_unused = ^imm_i[31:21];

  // Format select: scatter the immediate and report the owned field mask
  always_comb begin
    pack_o = 32'h0000_0000;
    mask_o = 32'h0000_0000;
    case (src_i)
      IMM_I: begin
        pack_o = {imm_i[11:0], 20'h00000};
        mask_o = IMM_MASK_I;
      end
      IMM_S: begin
        pack_o = {imm_i[11:5], 13'h0000, imm_i[4:0], 7'h00};
        mask_o = IMM_MASK_S;
      end
      IMM_B: begin
        pack_o = {imm_i[12], imm_i[10:5], 13'h0000, imm_i[4:1], imm_i[11], 7'h00};
        mask_o = IMM_MASK_B;
      end
      IMM_J: begin
        pack_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'h000};
        mask_o = IMM_MASK_J;
      end
      default: begin
        pack_o = 32'h0000_0000;
        mask_o = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline merging a packed immediate into a base word.
// Optional range checking and error counting under IMM_RANGE_CHECK_EN.
module imm_encoder
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_base,
  input  logic [31:0] in_imm,
  input  logic [1:0]  in_imm_src,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_cnt
);

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_base_q, s1_base_d;
  logic [31:0] s1_imm_q, s1_imm_d;
  imm_src_e    s1_src_q, s1_src_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        s2_adv, s1_adv;
  logic [31:0] pack_s, mask_s;

  imm_pack u_pack (
    .imm_i  (s1_imm_q),
    .src_i  (s1_src_q),
    .pack_o (pack_s),
    .mask_o (mask_s)
  );

  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Next-state for both pipeline stages
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_base_d   = s1_base_q;
    s1_imm_d    = s1_imm_q;
    s1_src_d    = s1_src_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_base_d = in_base;
        s1_imm_d  = in_imm;
        s1_src_d  = imm_src_e'(in_imm_src);
      end else begin
        s1_base_d = s1_base_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_instr_d = (s1_base_q & ~mask_s) | pack_s;
      end else begin
        out_instr_d = out_instr_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_base_q   <= 32'h0000_0000;
      s1_imm_q    <= 32'h0000_0000;
      s1_src_q    <= IMM_I;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_base_q   <= s1_base_d;
      s1_imm_q    <= s1_imm_d;
      s1_src_q    <= s1_src_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;

`ifdef IMM_RANGE_CHECK_EN
  logic        s1_err_q, s1_err_d;
  logic        out_err_q, out_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Range flag rides with its payload; counter saturates on delivered errors
  always_comb begin
    s1_err_d  = s1_err_q;
    out_err_d = out_err_q;
    err_cnt_d = err_cnt_q;
    if (s1_adv && in_valid) begin
      s1_err_d = imm_out_of_range(in_imm, imm_src_e'(in_imm_src));
    end else begin
      s1_err_d = s1_err_q;
    end
    if (s2_adv && s1_valid_q) begin
      out_err_d = s1_err_q;
    end else begin
      out_err_d = out_err_q;
    end
    if (out_valid_q && out_ready && out_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'h0001;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error-path registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err_q  <= 1'b0;
      out_err_q <= 1'b0;
      err_cnt_q <= 16'h0000;
    end else begin
      s1_err_q  <= s1_err_d;
      out_err_q <= out_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_err = out_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign out_err = 1'b0;
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed spec vectors plus a randomized
// stream checked against a bit-mapping reference model and scoreboard.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_base = 32'h0;
  logic [31:0] in_imm = 32'h0;
  logic [1:0]  in_imm_src = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'h0;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_imm(in_imm), .in_imm_src(in_imm_src),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Which immediate bit lands in instruction bit i for a format (-1: base bit kept)
  function automatic int src_bit(input int fmt, input int i);
    case (fmt)
      0: return (i >= 20) ? i - 20 : -1;
      1: if (i >= 25) return i - 20; else if (i >= 7 && i <= 11) return i - 7; else return -1;
      2: if (i == 31) return 12; else if (i >= 25) return i - 20;
         else if (i >= 8 && i <= 11) return i - 7; else if (i == 7) return 11; else return -1;
      default: if (i == 31) return 20; else if (i >= 21) return i - 20;
               else if (i == 20) return 11; else if (i >= 12) return i; else return -1;
    endcase
  endfunction

  function automatic logic [31:0] ref_instr(input logic [31:0] b, input logic [31:0] im, input int fmt);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = (src_bit(fmt, i) < 0) ? b[i] : im[src_bit(fmt, i)];
    end
    return r;
  endfunction

  function automatic logic ref_err(input logic [31:0] im, input int fmt);
`ifdef IMM_RANGE_CHECK_EN
    longint v;
    v = longint'($signed(im));
    case (fmt)
      0, 1: return (v < -2048) || (v > 2047);
      2:    return (v < -4096) || (v > 4094) || (v % 2 != 0);
      default: return (v < -1048576) || (v > 1048574) || (v % 2 != 0);
    endcase
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'h1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'h0;
  endtask

  // Push one request with out_ready high; report edges until out_valid
  task automatic send_one(input logic [31:0] b, input logic [31:0] im, input logic [1:0] s,
                          output int lat, output logic [31:0] instr, output logic err);
    @(negedge clk);
    in_base = b; in_imm = im; in_imm_src = s; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1; instr = 32'h0; err = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        lat = c; instr = out_instr; err = out_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got %b want 0", out_err); end
    n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_err_cnt got %h want 0", err_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_formats();
    logic [31:0] vb [4] = '{32'h0000_0013, 32'h0000_2023, 32'h0000_0063, 32'h0000_006F};
    logic [31:0] vi [4] = '{32'hFFFF_FFFF, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0000_0008};
    logic [31:0] vx [4] = '{32'hFFF0_0013, 32'h0000_2423, 32'hFE00_0EE3, 32'h0080_006F};
    int lat; logic [31:0] ins; logic e;
    for (int k = 0; k < 4; k++) begin
      send_one(vb[k], vi[k], k[1:0], lat, ins, e);
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL fmt%0d_latency got %0d want 2", k, lat); end
      n_cmp++; if (ins !== vx[k]) begin n_bad++; $display("FAIL fmt%0d_instr got %h want %h", k, ins, vx[k]); end
      n_cmp++; if (ins !== ref_instr(vb[k], vi[k], k)) begin n_bad++; $display("FAIL fmt%0d_model got %h want %h", k, ins, ref_instr(vb[k], vi[k], k)); end
      n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL fmt%0d_err got %b want 0", k, e); end
    end
  endtask

  task automatic test_range();
    logic [31:0] vi [3] = '{32'h0000_0003, 32'h0000_0800, 32'h000F_FFFE};
    int          vf [3] = '{2, 0, 3};
    logic        ve [3];
    int lat; logic [31:0] ins; logic e;
`ifdef IMM_RANGE_CHECK_EN
    ve = '{1'b1, 1'b1, 1'b0};
`else
    ve = '{1'b0, 1'b0, 1'b0};
`endif
    for (int k = 0; k < 3; k++) begin
      send_one(32'h0000_0013, vi[k], vf[k][1:0], lat, ins, e);
      n_cmp++; if (e !== ve[k] || e !== ref_err(vi[k], vf[k])) begin n_bad++; $display("FAIL range%0d_err got %b want %b", k, e, ve[k]); end
      n_cmp++; if (ins !== ref_instr(32'h0000_0013, vi[k], vf[k])) begin n_bad++; $display("FAIL range%0d_instr got %h want %h", k, ins, ref_instr(32'h0000_0013, vi[k], vf[k])); end
      if (ve[k]) exp_cnt = sat_inc(exp_cnt);
      @(negedge clk);
      n_cmp++; if (err_cnt !== exp_cnt) begin n_bad++; $display("FAIL range%0d_err_cnt got %0d want %0d", k, err_cnt, exp_cnt); end
    end
  endtask

  task automatic test_merge();
    int lat; logic [31:0] ins; logic e; logic [31:0] m;
    for (int k = 0; k < 4; k++) begin
      m = 32'h0;
      for (int i = 0; i < 32; i++) m[i] = (src_bit(k, i) >= 0);
      send_one(32'hFFFF_FFFF, 32'h0, k[1:0], lat, ins, e);
      n_cmp++; if (ins !== ~m) begin n_bad++; $display("FAIL merge%0d got %h want %h", k, ins, ~m); end
    end
  endtask

  // Streams n requests through the DUT with a scoreboard; stall_mode selects
  // the fixed backpressure pattern instead of random valid/ready
  task automatic run_stream(input int n, input bit stall_mode, input string tag);
    logic [31:0] q_ins [$];
    logic        q_err [$];
    int   sent = 0, got = 0, occ = 0, cyc = 0;
    bit   held = 0, saw_low = 0;
    logic [31:0] held_ins = 32'h0;
    logic [31:0] b, im; int f;
    bit acc, dlv;
    b = $urandom; im = $urandom; f = $urandom_range(0, 3);
    while (got < n && cyc < 40 * n + 40) begin
      cyc++;
      @(negedge clk);
      if (stall_mode) begin
        out_ready = !(cyc >= 2 && cyc <= 4);
        in_valid  = (sent < n);
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      end
      in_base = b; in_imm = im; in_imm_src = f[1:0];
      #1;
      if (in_ready !== !(occ == 2 && !out_ready)) begin
        n_cmp++; n_bad++; $display("FAIL %s_in_ready cyc %0d got %b want %b", tag, cyc, in_ready, !(occ == 2 && !out_ready));
      end
      if (!in_ready) saw_low = 1;
      if (held) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_instr !== held_ins) begin
          n_bad++; $display("FAIL %s_stall_hold got %b/%h want 1/%h", tag, out_valid, out_instr, held_ins);
        end
      end
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        n_cmp++;
        if (q_ins.size() == 0) begin
          n_bad++; $display("FAIL %s_extra_output got %h want none", tag, out_instr);
        end else if (out_instr !== q_ins[0] || out_err !== q_err[0]) begin
          n_bad++; $display("FAIL %s_data got %h/%b want %h/%b", tag, out_instr, out_err, q_ins[0], q_err[0]);
        end
        if (q_err.size() != 0) begin
          if (q_err[0]) exp_cnt = sat_inc(exp_cnt);
          void'(q_ins.pop_front()); void'(q_err.pop_front());
        end
        got++;
      end
      held = out_valid && !out_ready;
      held_ins = out_instr;
      if (acc) begin
        q_ins.push_back(ref_instr(b, im, f));
        q_err.push_back(ref_err(im, f));
        sent++;
        b = $urandom; f = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0: im = $urandom_range(0, 4095) - 2048;
          1: im = $urandom_range(0, 2) == 0 ? 32'h0000_0800 : 32'hFFF0_0000;
          2: im = $urandom & 32'hFFFF_FFFE;
          default: im = $urandom;
        endcase
      end
      occ = occ + (acc ? 1 : 0) - (dlv ? 1 : 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got != n || q_ins.size() != 0) begin n_bad++; $display("FAIL %s_count got %0d want %0d", tag, got, n); end
    if (stall_mode) begin
      n_cmp++; if (!saw_low) begin n_bad++; $display("FAIL %s_ready_drop got 0 want 1", tag); end
    end
    #1;
    n_cmp++; if (err_cnt !== exp_cnt) begin n_bad++; $display("FAIL %s_err_cnt got %0d want %0d", tag, err_cnt, exp_cnt); end
  endtask

  task automatic test_reset_midflight();
    int lat; logic [31:0] ins; logic e;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_base = 32'h1234_5013; in_imm = 32'h5; in_imm_src = 2'b00;
    @(negedge clk);
    in_imm = 32'h6;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_fill got %b/%b want 1/0", out_valid, in_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin n_bad++; $display("FAIL rst_async got %b/%h want 0/0", out_valid, out_instr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1; exp_cnt = 16'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ghost cyc %0d got %b want 0", c, out_valid); end
    end
    send_one(32'h0000_0023, 32'hFFFF_F800, 2'b01, lat, ins, e);
    n_cmp++; if (lat != 2 || ins !== ref_instr(32'h0000_0023, 32'hFFFF_F800, 1)) begin
      n_bad++; $display("FAIL rst_after got %0d/%h want 2/%h", lat, ins, ref_instr(32'h0000_0023, 32'hFFFF_F800, 1));
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_range();
    test_merge();
    run_stream(4, 1'b1, "backpressure");
    run_stream(300, 1'b0, "random");
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
